uart_tx: RTL and testbench

//  Transmit half of the podule serial port: host writes to the UART data register fill a FIFO;

---
 rtl/uart_tx_pkg.sv | 14 +
 rtl/uart_tx_sync_fifo.sv | 67 ++++++
 rtl/uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and line constants, also used by uart_rx.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic        TXD_IDLE  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO with level counter; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next pointer and level values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-fed 8N1/8N2 serialiser with optional CTS flow control.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IRQ_LEVEL  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_stb,
  input  logic [7:0]                    wr_data,
  input  logic [15:0]                   divisor,
  input  logic                          two_stop,
  input  logic                          cts_en,
  input  logic                          serial_cts,
  input  logic                          ovr_clr,
  output logic                          txd,
  output logic                          tx_irq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          busy,
  output logic                          overrun
);

  tx_state_e   state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] div_q, div_d;
  logic        two_stop_q, two_stop_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        txd_q, txd_d;
  logic        overrun_q, overrun_d;
  logic        tx_irq_q, tx_irq_d;
  logic        cts_meta_q, cts_sync_q;

  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        start_ok;
  logic        bit_done;
  logic        pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_stb),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign start_ok = !fifo_empty && (!cts_en || cts_sync_q);
  assign bit_done = (timer_q == '0);

  assign txd     = txd_q;
  assign tx_irq  = tx_irq_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != ST_IDLE) || !fifo_empty;

  // Two-flop synchroniser for the asynchronous CTS input
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_meta_q <= 1'b0;
      cts_sync_q <= 1'b0;
    end else begin
      cts_meta_q <= serial_cts;
      cts_sync_q <= cts_meta_q;
    end
  end

  // FSM, bit timer and shifter next-state; txd is computed from the next state so the
  // registered line changes on the same edge as the state it belongs to.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    div_d      = div_q;
    two_stop_d = two_stop_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          pop        = 1'b1;
          state_d    = ST_START;
          shift_d    = fifo_rd_data;
          div_d      = divisor;
          timer_d    = divisor;
          two_stop_d = two_stop;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          timer_d   = div_q;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          timer_d = div_q;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            timer_d    = div_q;
          end else if (start_ok) begin
            pop        = 1'b1;
            state_d    = ST_START;
            shift_d    = fifo_rd_data;
            div_d      = divisor;
            timer_d    = divisor;
            two_stop_d = two_stop;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = TXD_IDLE;
    endcase
  end

  // Overrun and interrupt next values; a dropped write beats a same-cycle clear
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (wr_stb && fifo_full && !pop) overrun_d = 1'b1;
    tx_irq_d = (32'(fifo_level) <= IRQ_LEVEL);
  end

  // Transmitter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      div_q      <= '0;
      two_stop_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= TXD_IDLE;
      overrun_q  <= 1'b0;
      tx_irq_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      two_stop_q <= two_stop_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      overrun_q  <= overrun_d;
      tx_irq_q   <= tx_irq_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: writes queue expected bytes, a line monitor decodes frames.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_stb;
  logic [7:0]  wr_data;
  logic [15:0] divisor;
  logic        two_stop;
  logic        cts_en;
  logic        serial_cts;
  logic        ovr_clr;
  logic        txd;
  logic        tx_irq;
  logic [4:0]  fifo_level;
  logic        fifo_full;
  logic        busy;
  logic        overrun;

  uart_tx #(
    .FIFO_DEPTH (16),
    .IRQ_LEVEL  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_stb     (wr_stb),
    .wr_data    (wr_data),
    .divisor    (divisor),
    .two_stop   (two_stop),
    .cts_en     (cts_en),
    .serial_cts (serial_cts),
    .ovr_clr    (ovr_clr),
    .txd        (txd),
    .tx_irq     (tx_irq),
    .fifo_level (fifo_level),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  int unsigned starts_q[$];
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: samples each bit at mid-period, compares decoded byte with scoreboard head
  bit         m_active = 1'b0;
  bit         m_two;
  int         m_cnt;
  int         m_p;
  logic [7:0] m_byte;
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      m_active = 1'b0;
    end else begin
      if (!m_active && txd == 1'b0) begin
        m_active = 1'b1;
        m_cnt    = 0;
        m_p      = int'(divisor) + 1;
        m_two    = two_stop;
        m_byte   = '0;
        starts_q.push_back(cyc);
      end
      if (m_active) begin
        if ((m_cnt % m_p) == (m_p / 2)) begin
          int k;
          k = m_cnt / m_p;
          if (k == 0) chk("start_bit", 32'(txd), 32'd0);
          else if (k <= 8) m_byte[k-1] = txd;
          else begin
            chk(k == 9 ? "stop_bit1" : "stop_bit2", 32'(txd), 32'd1);
            if (k == 10 || !m_two) begin
              m_active = 1'b0;
              if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL frame: got unexpected byte 0x%0h, scoreboard empty", m_byte);
              end else begin
                chk("frame_byte", 32'(m_byte), 32'(exp_q.pop_front()));
              end
            end
          end
        end
        m_cnt++;
      end
    end
  end

  task automatic wr(input logic [7:0] b, input bit accept);
    wr_stb  = 1'b1;
    wr_data = b;
    if (accept && mon_en) exp_q.push_back(b);
    @(negedge clk);
    wr_stb = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int bound);
    int i;
    for (i = 0; i < bound && starts_q.size() < n; i++) @(negedge clk);
    if (starts_q.size() < n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_start: got %0d frame starts expected %0d", starts_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound && (busy || m_active); i++) @(negedge clk);
    if (busy || m_active) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: got busy=%0d expected 0", busy);
    end
  endtask

  initial begin
    int unsigned s;
    int unsigned c0;
    int          lat;
    int          i;
    logic        txd_and;

    rst = 1'b1; wr_stb = 1'b0; wr_data = '0; divisor = 16'd3; two_stop = 1'b0;
    cts_en = 1'b0; serial_cts = 1'b1; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_irq", 32'(tx_irq), 32'd1);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single 8N1 frame, 4 clk per bit; busy falls exactly at end of stop bit
    @(negedge clk);
    wr(8'hA5, 1'b1);
    wait_starts(1, 20);
    s = (starts_q.size() > 0) ? starts_q[0] : cyc;
    for (i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("busy_drop_cycles", cyc - s, 32'd40);
    chk("idle_txd", 32'(txd), 32'd1);
    wait_idle(20);
    starts_q.delete();

    // Two stop bits, back-to-back frames: no idle gap between them
    two_stop = 1'b1;
    @(negedge clk);
    wr(8'h00, 1'b1);
    wr(8'hFF, 1'b1);
    wait_starts(2, 200);
    if (starts_q.size() >= 2) chk("b2b_frame_spacing", starts_q[1] - starts_q[0], 32'd44);
    wait_idle(100);
    two_stop = 1'b0;
    starts_q.delete();

    // CTS gating: hold while deasserted, start within 3 clk of raising it
    serial_cts = 1'b0;
    cts_en     = 1'b1;
    divisor    = 16'd1;
    repeat (3) @(negedge clk);
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    txd_and = 1'b1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      txd_and = txd_and & txd;
    end
    chk("cts_hold_txd", 32'(txd_and), 32'd1);
    chk("cts_hold_level", 32'(fifo_level), 32'd3);
    c0 = cyc;
    serial_cts = 1'b1;
    wait_starts(1, 20);
    lat = (starts_q.size() > 0) ? int'(starts_q[0] - c0) : 99;
    vectors++;
    if (lat > 3 || lat < 1) begin
      miscompares++;
      $display("FAIL cts_latency: got %0d clk expected 1..3", lat);
    end
    // Divisor change mid-frame must only affect later frames (monitor latches it per frame)
    divisor = 16'd5;
    wait_idle(300);
    cts_en = 1'b0;
    starts_q.delete();

    // Fill to full, overflow write, overrun set/clear priority
    cts_en     = 1'b1;
    serial_cts = 1'b0;
    divisor    = 16'd0;
    repeat (3) @(negedge clk);
    for (i = 0; i < 16; i++) wr(8'(i * 13 + 7), 1'b1);
    chk("fill_level", 32'(fifo_level), 32'd16);
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_overrun", 32'(overrun), 32'd0);
    chk("fill_irq", 32'(tx_irq), 32'd0);
    wr(8'hEE, 1'b0);
    chk("ovf_overrun", 32'(overrun), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_full", 32'(fifo_full), 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    ovr_clr = 1'b1;
    wr(8'hDD, 1'b0);
    ovr_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    serial_cts = 1'b1;
    wait_idle(400);
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_irq", 32'(tx_irq), 32'd1);

    // Interrupt threshold: 6 queued -> irq low; rises one clk after level reaches 4
    serial_cts = 1'b0;
    divisor    = 16'd9;
    repeat (3) @(negedge clk);
    for (i = 0; i < 6; i++) wr(8'(8'h40 + i), 1'b1);
    @(negedge clk);
    chk("irq6_level", 32'(fifo_level), 32'd6);
    chk("irq6_irq", 32'(tx_irq), 32'd0);
    serial_cts = 1'b1;
    for (i = 0; i < 400 && fifo_level != 5'd4; i++) @(negedge clk);
    chk("irq_level4", 32'(fifo_level), 32'd4);
    chk("irq_lag", 32'(tx_irq), 32'd0);
    @(negedge clk);
    chk("irq_rise", 32'(tx_irq), 32'd1);
    wait_idle(1000);
    cts_en = 1'b0;
    starts_q.delete();

    // Reset mid data bit 3: line returns high, FIFO flushed, next byte clean
    mon_en  = 1'b0;
    divisor = 16'd3;
    @(negedge clk);
    wr(8'h00, 1'b0);
    wr(8'h00, 1'b0);
    wr(8'h00, 1'b0);
    for (i = 0; i < 20 && txd; i++) @(negedge clk);
    repeat (17) @(negedge clk);
    chk("pre_rst_txd", 32'(txd), 32'd0);
    chk("pre_rst_level", 32'(fifo_level), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    wr(8'h3C, 1'b1);
    wait_idle(200);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
